uart_tx_bit_sampler: RTL and testbench
======================================

Name: uart_tx_bit_sampler

Overview:
- UART transmit serializer; the transmit-side counterpart of the 16x-oversampled receive bit-sample counter.
- Accepts bytes on a valid/ready handshake and emits 8N1 frames (start, 8 data bits LSB-first, stop) on a serial line.
- Bit timing uses the same sample-tick scheme as the receiver: a prescaler produces sample ticks, and a sample counter counts SAMPLES_PER_BIT ticks per bit.
- Has a one-entry holding register so the next byte can be accepted while the current frame shifts out.

Parameters:
- CLKS_PER_SAMPLE, 4, clk cycles per sample tick (>=1).
- SAMPLES_PER_BIT, 16, sample ticks per serial bit (>=2); matches the receiver oversampling.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty; the byte is accepted when tx_valid && tx_ready at a rising edge.
- tx_out  output  1  serial line, idles high.
- tx_busy  output  1  high while a frame is on the line (START through STOP).
- tx_done  output  1  one-cycle pulse on the last clk of each stop bit.

Behaviour:
- Reset (async, rst_n=0):
  - tx_out=1, tx_ready=1, tx_busy=0, tx_done=0.
  - State IDLE; prescaler, sample counter and bit index cleared; holding register marked empty.
  - A reset asserted mid-frame forces tx_out high immediately and discards both the shifting and the held byte.
- Bit period: BIT_CLKS = CLKS_PER_SAMPLE*SAMPLES_PER_BIT clks.
  - Prescaler counts 0..CLKS_PER_SAMPLE-1 and wraps, producing a sample tick on the wrap.
  - Sample counter counts ticks 0..SAMPLES_PER_BIT-1; its wrap ends the bit.
  - Counter widths are $clog2 of the respective modulus, minimum 1.
  - Prescaler and sample counter are cleared on every IDLE->START transition, so frames are phase-aligned to acceptance.
- Handshake:
  - Accept into the holding register when tx_valid && tx_ready. tx_ready drops the cycle after acceptance.
  - tx_ready rises again the cycle after the held byte moves into the shift register.
  - tx_data is ignored when tx_ready=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_out=1.
  - If the holding register is full: load the shift register, free the holding register, go to START next cycle.
  - Latency: accept at edge N -> tx_out=0 from edge N+2 (one cycle to hold, one to load).
- START: tx_out=0 for BIT_CLKS clks, then go to DATA with bit index 0.
- DATA:
  - tx_out = shift[0]; shift right at each bit end.
  - Bit index increments at each bit end; after bit DATA_BITS-1 go to STOP.
- STOP:
  - tx_out=1 for BIT_CLKS clks.
  - tx_done=1 on the final clk.
  - If the holding register is full at that clk: load it and go directly to START (no idle gap; tx_busy stays 1). Otherwise go to IDLE.
- Simultaneous events:
  - Acceptance in the same cycle the held byte is loaded into the shifter is allowed; tx_ready is computed so no byte is lost or duplicated.
  - At most one byte is in flight plus one held.
- tx_busy = (state != IDLE).
- Total frame = 10*BIT_CLKS clks for DATA_BITS=8.

Test Plan:
- Reset: rst_n=0 for 3 clks, then release -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0. Assert rst_n=0 mid-DATA -> tx_out=1 in the same cycle, tx_ready=1, and no tx_done afterwards.
- Single byte, CLKS_PER_SAMPLE=2, SAMPLES_PER_BIT=16 (BIT_CLKS=32): send 0xA5 -> tx_out low from edge N+2 for 32 clks, then bits 1,0,1,0,0,1,0,1 at 32 clks each, then high for 32 clks. tx_done pulses exactly once, 320 clks after the start bit begins.
- Back-to-back: present 0x00 then 0xFF with tx_valid held high -> second byte accepted during the first frame, tx_ready=0 until it is loaded. Second start bit begins the clk after the first tx_done, with no idle gap. Line shows 320 clks for 0x00 framing, then 0xFF framing.
- Backpressure: three bytes 0x11, 0x22, 0x33 with tx_valid held high -> 0x33 is not accepted until 0x22 loads. The line carries all three frames in order with nothing dropped or duplicated.
- Boundary timing, CLKS_PER_SAMPLE=1, SAMPLES_PER_BIT=2: send 0x80 -> each bit is exactly 2 clks (start low, seven 0s, one 1, stop high). tx_busy is high for exactly 20 clks.
- Idle stability: tx_valid=0 for 1000 clks -> tx_out stays 1, tx_busy stays 0, and tx_done never pulses.

Source files
------------

// File: rtl/uart_tx_bit_sampler.sv
// UART 8N1 transmitter with a one-entry holding register. Bit timing comes from
// a prescaler feeding a sample counter, mirroring the oversampled receiver.
module uart_tx_bit_sampler #(
  parameter int CLKS_PER_SAMPLE = 4,
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int PW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int SW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SAMPLE - 1);
  localparam logic [SW-1:0] SAMP_LAST  = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state;
  logic [PW-1:0]        r_presc;
  logic [SW-1:0]        r_samp;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hold_data;
  logic                 r_hold_full;
  logic                 r_tx_out;
  logic                 r_tx_busy;
  logic                 r_tx_done;

  logic w_tick;
  logic w_bit_end;
  logic w_accept;
  logic w_load;

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_bit_end = w_tick && (r_samp == SAMP_LAST);
  assign w_accept  = tx_valid && !r_hold_full;
  assign w_load    = r_hold_full &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign tx_ready = !r_hold_full;
  assign tx_out   = r_tx_out;
  assign tx_busy  = r_tx_busy;
  assign tx_done  = r_tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= tx_data;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Outputs are registered from the current state, so the line trails the
  // state by one clk; tx_busy and tx_done share that lag and stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_samp    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx_out  <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_out  <= (r_state == S_START) ? 1'b0 :
                   (r_state == S_DATA)  ? r_shift[0] : 1'b1;
      r_tx_busy <= (r_state != S_IDLE);
      r_tx_done <= (r_state == S_STOP) && w_bit_end;

      if (r_state == S_IDLE) begin
        r_presc <= '0;
        r_samp  <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          r_samp <= (r_samp == SAMP_LAST) ? '0 : r_samp + SW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_shift   <= r_hold_data;
            r_bit_idx <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == BIT_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
            end
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (w_load) begin
              r_shift   <= r_hold_data;
              r_bit_idx <= '0;
              r_state   <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_bit_sampler.sv
// Scoreboard bench: stimulus queues expected frames, line monitors decode and compare.
module tb_uart_tx_bit_sampler;

  localparam int BIT_A   = 32;
  localparam int FRAME_A = 10 * BIT_A;
  localparam int BIT_B   = 2;
  localparam int FRAME_B = 10 * BIT_B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data_a = 8'h00;
  logic [7:0] tx_data_b = 8'h00;
  logic       tx_valid_a = 1'b0;
  logic       tx_valid_b = 1'b0;
  logic       tx_ready_a, tx_out_a, tx_busy_a, tx_done_a;
  logic       tx_ready_b, tx_out_b, tx_busy_b, tx_done_b;

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;
  int stray_done = 0;
  int busy_cnt_b = 0;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         exp_lat;
    int         exp_gap;
  } exp_t;

  exp_t       qa[$];
  logic [7:0] qb[$];

  uart_tx_bit_sampler #(.CLKS_PER_SAMPLE(2), .SAMPLES_PER_BIT(16), .DATA_BITS(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx_out(tx_out_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
  );

  uart_tx_bit_sampler #(.CLKS_PER_SAMPLE(1), .SAMPLES_PER_BIT(2), .DATA_BITS(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx_out(tx_out_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called on a negedge; returns on the negedge just after the accepting edge.
  task automatic send_a(input logic [7:0] b, input int exp_lat, input int exp_gap,
                        input int exp_wait);
    int   w;
    exp_t e;
    w = 0;
    tx_data_a  = b;
    tx_valid_a = 1'b1;
    while (!tx_ready_a && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready_a) begin
      chk("ready_timeout", 1, 0);
      tx_valid_a = 1'b0;
      return;
    end
    if (exp_wait >= 0) chk($sformatf("ready_wait_%02h", b), w, exp_wait);
    @(negedge clk);
    e.data = b;
    e.acc = cyc;
    e.exp_lat = exp_lat;
    e.exp_gap = exp_gap;
    qa.push_back(e);
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("drain_a", qa.size(), 0);
  endtask

  initial begin : mon_a
    logic [FRAME_A-1:0] line_c, done_c, busy_c;
    logic [9:0]         fr;
    bit                 in_f;
    int                 idx, gap, start_c, bad;
    exp_t               e;
    in_f = 0; idx = 0; gap = 9999; start_c = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_f = 0;
        gap  = 9999;
      end else if (!in_f && tx_out_a) begin
        if (tx_done_a) stray_done++;
        if (gap < 9999) gap++;
      end else begin
        if (!in_f) begin
          in_f = 1; idx = 0; start_c = cyc;
        end
        line_c[idx] = tx_out_a;
        done_c[idx] = tx_done_a;
        busy_c[idx] = tx_busy_a;
        idx++;
        if (idx == FRAME_A) begin
          in_f = 0;
          if (qa.size() == 0) begin
            chk("unexpected_frame_a", 1, 0);
          end else begin
            e  = qa.pop_front();
            fr = {1'b1, e.data, 1'b0};
            bad = 0;
            for (int i = 0; i < FRAME_A; i++) if (line_c[i] !== fr[i / BIT_A]) bad++;
            chk($sformatf("frame_line_%02h", e.data), bad, 0);
            bad = 0;
            for (int i = 0; i < FRAME_A; i++) if (done_c[i] !== (i == FRAME_A - 1)) bad++;
            chk($sformatf("done_pulse_%02h", e.data), bad, 0);
            bad = 0;
            for (int i = 0; i < FRAME_A; i++) if (busy_c[i] !== 1'b1) bad++;
            chk($sformatf("busy_span_%02h", e.data), bad, 0);
            if (e.exp_lat >= 0) chk($sformatf("start_latency_%02h", e.data), start_c - e.acc, e.exp_lat);
            if (e.exp_gap >= 0) chk($sformatf("idle_gap_%02h", e.data), gap, e.exp_gap);
          end
          gap = 0;
        end
      end
    end
  end

  initial begin : mon_b
    logic [FRAME_B-1:0] line_c;
    logic [9:0]         fr;
    logic [7:0]         d;
    bit                 in_f;
    int                 idx, bad;
    in_f = 0; idx = 0;
    forever begin
      @(negedge clk);
      if (tx_busy_b === 1'b1) busy_cnt_b++;
      if (!rst_n) begin
        in_f = 0;
      end else if (in_f || !tx_out_b) begin
        if (!in_f) begin
          in_f = 1; idx = 0;
        end
        line_c[idx] = tx_out_b;
        idx++;
        if (idx == FRAME_B) begin
          in_f = 0;
          if (qb.size() == 0) begin
            chk("unexpected_frame_b", 1, 0);
          end else begin
            d  = qb.pop_front();
            fr = {1'b1, d, 1'b0};
            bad = 0;
            for (int i = 0; i < FRAME_B; i++) if (line_c[i] !== fr[i / BIT_B]) bad++;
            chk($sformatf("frame_line_b_%02h", d), bad, 0);
          end
        end
      end
    end
  end

  initial begin : stim
    int busy0, bad, w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_tx_out", tx_out_a, 1);
    chk("reset_tx_ready", tx_ready_a, 1);
    chk("reset_tx_busy", tx_busy_a, 0);
    chk("reset_tx_done", tx_done_a, 0);
    chk("reset_tx_out_b", tx_out_b, 1);

    // Single byte: 0xA5 starts two clks after acceptance
    send_a(8'hA5, 2, -1, 0);
    tx_valid_a = 1'b0;
    drain_a();

    // Back-to-back: 0xFF waits one clk for ready, then follows with no gap
    send_a(8'h00, 2, -1, 0);
    send_a(8'hFF, -1, 0, 1);
    tx_valid_a = 1'b0;
    drain_a();

    // Backpressure: 0x33 waits until 0x11's stop ends (320 - 1 clks)
    send_a(8'h11, 2, -1, 0);
    send_a(8'h22, -1, 0, 1);
    send_a(8'h33, -1, 0, FRAME_A - 1);
    tx_valid_a = 1'b0;
    drain_a();

    // Minimum timing on the second instance: 2 clks per bit, 20-clk frame
    tx_data_b  = 8'h80;
    tx_valid_b = 1'b1;
    busy0 = busy_cnt_b;
    w = 0;
    while (!tx_ready_b && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_b", tx_ready_b, 1);
    @(negedge clk);
    qb.push_back(8'h80);
    tx_valid_b = 1'b0;
    repeat (40) @(negedge clk);
    chk("busy_clks_b", busy_cnt_b - busy0, FRAME_B);
    chk("drain_b", qb.size(), 0);

    // Idle stability
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_out_a !== 1'b1 || tx_busy_a !== 1'b0 || tx_done_a !== 1'b0) bad++;
    end
    chk("idle_stable", bad, 0);

    // Reset mid-DATA with a byte shifting and another held
    send_a(8'h00, -1, -1, -1);
    send_a(8'h5A, -1, -1, -1);
    tx_valid_a = 1'b0;
    repeat (60) @(negedge clk);
    chk("pre_reset_line", tx_out_a, 0);
    chk("pre_reset_ready", tx_ready_a, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_tx_out", tx_out_a, 1);
    chk("midreset_tx_ready", tx_ready_a, 1);
    chk("midreset_tx_busy", tx_busy_a, 0);
    chk("midreset_tx_done", tx_done_a, 0);
    qa.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    chk("post_reset_busy", tx_busy_a, 0);
    chk("stray_done", stray_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
